// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage and the iterative multiply/divide unit.
// The core drives the master side; the unit implements the slave side.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;

  modport master (output start, op, a, b, input busy, done, hi, lo, div_by_zero);
  modport slave  (input start, op, a, b, output busy, done, hi, lo, div_by_zero);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MIPS-style multiply/divide unit: one radix-2 step per cycle over a magnitude
// datapath, with the signs of the results restored in the final cycle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset,
  muldiv_unit_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_PREP, S_CALC, S_FIX} state_t;

  state_t             r_state, w_state_next;
  logic [CW-1:0]      r_cnt;
  logic [1:0]         r_op;
  logic [WIDTH-1:0]   r_a, r_b, r_mag;
  logic [2*WIDTH-1:0] r_acc;
  logic               r_neg_q, r_neg_r;
  logic [WIDTH-1:0]   r_hi, r_lo;
  logic               r_dbz, r_done;
  logic               w_busy;

  logic               w_is_div, w_a_neg, w_b_neg, w_b_zero, w_ge;
  logic [WIDTH-1:0]   w_abs_a, w_abs_b;
  logic [WIDTH:0]     w_mul_sum, w_shift, w_diff;
  logic [2*WIDTH-1:0] w_mul_next, w_div_next, w_prod;
  logic [WIDTH-1:0]   w_quo, w_rem;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_next = S_PREP;
      S_PREP:  w_state_next = S_CALC;
      S_CALC:  if (r_cnt == '0) w_state_next = S_FIX;
      S_FIX:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy = (r_state != S_IDLE);
  end

  always_comb begin
    w_is_div = r_op[1];
    w_a_neg  = r_op[0] & r_a[WIDTH-1];
    w_b_neg  = r_op[0] & r_b[WIDTH-1];
    w_b_zero = (r_b == '0);
    w_abs_a  = w_a_neg ? -r_a : r_a;
    w_abs_b  = w_b_neg ? -r_b : r_b;
    // Multiply: low half holds the shrinking multiplier, high half the partial product.
    w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mag} : '0);
    w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};
    // Divide: high half is the remainder, low half shifts dividend out and quotient in.
    w_shift    = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    w_diff     = w_shift - {1'b0, r_mag};
    w_ge       = ~w_diff[WIDTH];
    w_div_next = {(w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0]), r_acc[WIDTH-2:0], w_ge};
    w_prod     = r_neg_q ? -r_acc : r_acc;
    w_quo      = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    w_rem      = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_mag   <= '0;
      r_acc   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_dbz   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= (r_state == S_FIX);
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_op <= bus.op;
            r_a  <= bus.a;
            r_b  <= bus.b;
          end
        end
        S_PREP: begin
          r_mag   <= w_is_div ? w_abs_b : w_abs_a;
          r_acc   <= {{WIDTH{1'b0}}, (w_is_div ? w_abs_a : w_abs_b)};
          r_neg_q <= w_a_neg ^ w_b_neg;
          r_neg_r <= w_a_neg;
          r_cnt   <= CW'(WIDTH - 1);
        end
        S_CALC: begin
          r_acc <= w_is_div ? w_div_next : w_mul_next;
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        end
        S_FIX: begin
          if (!w_is_div) begin
            r_hi  <= w_prod[2*WIDTH-1:WIDTH];
            r_lo  <= w_prod[WIDTH-1:0];
            r_dbz <= 1'b0;
          end else if (w_b_zero) begin
            // Zero divisor still runs the full iteration; the result is substituted here.
            r_hi  <= r_a;
            r_lo  <= '1;
            r_dbz <= 1'b1;
          end else begin
            r_hi  <= w_rem;
            r_lo  <= w_quo;
            r_dbz <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = w_busy;
  assign bus.done        = r_done;
  assign bus.hi          = r_hi;
  assign bus.lo          = r_lo;
  assign bus.div_by_zero = r_dbz;
endmodule
